// File: rtl/reset_request_sequencer.sv
// reset_request_sequencer
// Round-robin arbiter for reset requests. Fires one trigger pulse at the
// reset flag generator for the winner and then follows the generator's
// reset / operational / init flag pulses to completion. Each wait phase has
// a timeout that retries the trigger. A cooldown window follows completion.
// Cause and error status are sticky.
module reset_request_sequencer #(
    parameter int REQUESTERS     = 4,
    parameter int TIMEOUTCYCLES  = 1048576,
    parameter int COOLDOWNCYCLES = 256
) (
    input  logic                  clk,
    input  logic                  sync_rst_n,
    input  logic                  clk_en,
    input  logic [REQUESTERS-1:0] ReqIn,
    output logic [REQUESTERS-1:0] ReqAck,
    output logic                  rst_trigger_out,
    input  logic                  sync_rst_flag_in,
    input  logic                  clk_en_flag_in,
    input  logic                  init_flag_in,
    output logic                  Busy,
    output logic [2:0]            Phase,
    output logic [REQUESTERS-1:0] CauseOut,
    output logic                  TimeoutErr,
    output logic [3:0]            RetryCount
);

    localparam int MAXCYC = (TIMEOUTCYCLES > COOLDOWNCYCLES) ? TIMEOUTCYCLES : COOLDOWNCYCLES;
    localparam int CNTW   = $clog2(MAXCYC + 1);
    localparam int PTRW   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    localparam logic [CNTW-1:0] TOLIM   = CNTW'(TIMEOUTCYCLES - 1);
    // Only compared when a cooldown exists; guarded so the constant never goes negative.
    localparam logic [CNTW-1:0] COOLLIM = CNTW'((COOLDOWNCYCLES > 0) ? COOLDOWNCYCLES - 1 : 0);
    localparam logic [PTRW-1:0] LASTIDX = PTRW'(REQUESTERS - 1);
    localparam logic [REQUESTERS-1:0] ONE = REQUESTERS'(1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TRIGGER   = 3'd1;
    localparam logic [2:0] WAIT_RST  = 3'd2;
    localparam logic [2:0] WAIT_OPER = 3'd3;
    localparam logic [2:0] WAIT_INIT = 3'd4;
    localparam logic [2:0] COOLDOWN  = 3'd5;

    logic [2:0]      state;
    logic [CNTW-1:0] phaseCnt;
    logic [PTRW-1:0] rrPtr;
    logic [PTRW-1:0] grant;
    logic [PTRW-1:0] grantIdx;
    logic            grantFound;
    logic            expectedFlag;
    int              idx;

    assign Phase = state;
    assign Busy  = (state != IDLE);

    // Round-robin search: first set request at or above rrPtr, wrapping.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        idx        = 0;
        for (int i = 0; i < REQUESTERS; i++) begin
            idx = (int'(rrPtr) + i) % REQUESTERS;
            if (!grantFound && ReqIn[idx]) begin
                grantFound = 1'b1;
                grantIdx   = PTRW'(idx);
            end
        end
    end

    // The one flag that advances the current wait state; others are ignored.
    always_comb begin
        expectedFlag = 1'b0;
        case (state)
            WAIT_RST:  expectedFlag = sync_rst_flag_in;
            WAIT_OPER: expectedFlag = clk_en_flag_in;
            WAIT_INIT: expectedFlag = init_flag_in;
            default:   expectedFlag = 1'b0;
        endcase
    end

    // Sequencer state, counters and registered outputs; frozen when clk_en is low.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state           <= IDLE;
            phaseCnt        <= '0;
            rrPtr           <= '0;
            grant           <= '0;
            rst_trigger_out <= 1'b0;
            ReqAck          <= '0;
            CauseOut        <= '0;
            TimeoutErr      <= 1'b0;
            RetryCount      <= 4'd0;
        end else if (clk_en) begin
            rst_trigger_out <= 1'b0;
            ReqAck          <= '0;
            phaseCnt        <= phaseCnt + 1'b1;
            case (state)
                IDLE: begin
                    if (grantFound) begin
                        grant           <= grantIdx;
                        CauseOut        <= ONE << grantIdx;
                        state           <= TRIGGER;
                        rst_trigger_out <= 1'b1;
                    end
                end
                TRIGGER: begin
                    state    <= WAIT_RST;
                    phaseCnt <= '0;
                end
                WAIT_RST, WAIT_OPER, WAIT_INIT: begin
                    if (expectedFlag) begin
                        phaseCnt <= '0;
                        if (state == WAIT_RST) begin
                            state <= WAIT_OPER;
                        end else if (state == WAIT_OPER) begin
                            state <= WAIT_INIT;
                        end else begin
                            ReqAck <= ONE << grant;
                            rrPtr  <= (grant == LASTIDX) ? '0 : grant + 1'b1;
                            state  <= (COOLDOWNCYCLES == 0) ? IDLE : COOLDOWN;
                        end
                    end else if (phaseCnt == TOLIM) begin
                        // Retry the same grant; no ack for the failed attempt.
                        TimeoutErr      <= 1'b1;
                        RetryCount      <= (RetryCount == 4'hF) ? 4'hF : RetryCount + 4'd1;
                        state           <= TRIGGER;
                        rst_trigger_out <= 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (phaseCnt == COOLLIM) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_request_sequencer.sv
// Bench for reset_request_sequencer: directed sequences with a scoreboard.
// Stimulus pushes expected causes/acks; a negedge monitor pops and compares.
module tb_reset_request_sequencer;

    localparam int R = 4;

    logic         clk = 1'b0;
    logic         sync_rst_n = 1'b0;
    logic         clk_en = 1'b1;
    logic [R-1:0] ReqIn = '0;
    logic [R-1:0] ReqAck;
    logic         rst_trigger_out;
    logic         rstF = 1'b0, operF = 1'b0, initF = 1'b0;
    logic         Busy;
    logic [2:0]   Phase;
    logic [R-1:0] CauseOut;
    logic         TimeoutErr;
    logic [3:0]   RetryCount;

    int tests = 0;
    int fails = 0;
    logic gateOn = 1'b0;
    logic [R-1:0] expCause[$];
    logic [R-1:0] expAck[$];
    logic [2:0]   phq[$];

    reset_request_sequencer #(.REQUESTERS(R), .TIMEOUTCYCLES(16), .COOLDOWNCYCLES(8)) dut (
        .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en), .ReqIn(ReqIn), .ReqAck(ReqAck),
        .rst_trigger_out(rst_trigger_out), .sync_rst_flag_in(rstF), .clk_en_flag_in(operF),
        .init_flag_in(initF), .Busy(Busy), .Phase(Phase), .CauseOut(CauseOut),
        .TimeoutErr(TimeoutErr), .RetryCount(RetryCount));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enable gating: alternate clk_en each cycle while gateOn is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (gateOn) clk_en = ~clk_en;
            else clk_en = 1'b1;
        end
    end

    // Monitor: trigger causes, trigger width in enabled cycles, acks.
    initial begin
        logic prevTrig, prevAck;
        int trigEn;
        prevTrig = 1'b0; prevAck = 1'b0; trigEn = 0;
        forever begin
            @(negedge clk);
            if (rst_trigger_out && !prevTrig) begin
                if (expCause.size() == 0) check("unexpected_trigger", 32'(CauseOut), 32'hdead);
                else check("trigger_cause", 32'(CauseOut), 32'(expCause.pop_front()));
            end
            if (rst_trigger_out && clk_en) trigEn++;
            if (!rst_trigger_out && prevTrig) begin
                check("trigger_len", 32'(trigEn), 32'd1);
                trigEn = 0;
            end
            if ((ReqAck != '0) && !prevAck) begin
                if (expAck.size() == 0) check("unexpected_ack", 32'(ReqAck), 32'hdead);
                else check("ack_value", 32'(ReqAck), 32'(expAck.pop_front()));
            end
            prevTrig = rst_trigger_out;
            prevAck  = (ReqAck != '0);
        end
    end

    task automatic checkReset(input string p);
        check({p, "_phase"}, 32'(Phase), 32'd0);
        check({p, "_busy"}, 32'(Busy), 32'd0);
        check({p, "_trig"}, 32'(rst_trigger_out), 32'd0);
        check({p, "_ack"}, 32'(ReqAck), 32'd0);
        check({p, "_cause"}, 32'(CauseOut), 32'd0);
        check({p, "_terr"}, 32'(TimeoutErr), 32'd0);
        check({p, "_retry"}, 32'(RetryCount), 32'd0);
    endtask

    task automatic doReset();
        sync_rst_n = 1'b0;
        tick();
        sync_rst_n = 1'b1;
    endtask

    task automatic waitTrig();
        int n = 0;
        while (!rst_trigger_out && n < 100) begin tick(); n++; end
        check("trigger_seen", 32'(rst_trigger_out), 32'd1);
        check("trigger_phase", 32'(Phase), 32'd1);
    endtask

    task automatic flagStep(input int which, input int gap, input logic [2:0] expPh);
        repeat (gap) tick();
        if (which == 0) rstF = 1'b1;
        else if (which == 1) operF = 1'b1;
        else initF = 1'b1;
        tick();
        rstF = 1'b0; operF = 1'b0; initF = 1'b0;
        check("flag_phase", 32'(Phase), 32'(expPh));
    endtask

    // Called right after the init edge: ack present, then cooldown length.
    task automatic ackCool(input logic [R-1:0] exp, input bit drop);
        int n = 0;
        check("ack_direct", 32'(ReqAck), 32'(exp));
        if (drop) ReqIn = ReqIn & ~exp;
        while (Busy && n < 50) begin tick(); n++; end
        check("cooldown_len", 32'(n), 32'd8);
    endtask

    task automatic finishSeq(input logic [R-1:0] exp, input bit drop);
        flagStep(0, 2, 3'd3);
        flagStep(1, 2, 3'd4);
        flagStep(2, 2, 3'd5);
        ackCool(exp, drop);
    endtask

    task automatic doSeq(input logic [R-1:0] exp, input bit drop);
        expCause.push_back(exp);
        expAck.push_back(exp);
        waitTrig();
        tick();
        check("wait_rst_phase", 32'(Phase), 32'd2);
        check("trig_dropped", 32'(rst_trigger_out), 32'd0);
        finishSeq(exp, drop);
    endtask

    initial begin
        logic [2:0] last;
        bit seen5;
        int n;
        logic [2:0] gexp [6];
        gexp[0] = 3'd1; gexp[1] = 3'd2; gexp[2] = 3'd3;
        gexp[3] = 3'd4; gexp[4] = 3'd5; gexp[5] = 3'd0;

        repeat (3) tick();
        checkReset("reset");
        sync_rst_n = 1'b1;
        tick();

        // Single request
        ReqIn = 4'b0010;
        doSeq(4'b0010, 1'b1);
        check("single_idle", 32'(Phase), 32'd0);

        // Round-robin from pointer 0 with all requests held
        doReset();
        ReqIn = 4'b1111;
        doSeq(4'b0001, 1'b0);
        doSeq(4'b0010, 1'b0);
        doSeq(4'b0100, 1'b0);
        doSeq(4'b1000, 1'b0);
        ReqIn = '0;

        // Flag wins over timeout at counter == 15
        doReset();
        tick();
        ReqIn = 4'b0010;
        expCause.push_back(4'b0010);
        expAck.push_back(4'b0010);
        waitTrig();
        tick();
        repeat (15) tick();
        check("fvt_still_wait", 32'(Phase), 32'd2);
        flagStep(0, 0, 3'd3);
        check("fvt_terr", 32'(TimeoutErr), 32'd0);
        check("fvt_retry", 32'(RetryCount), 32'd0);
        flagStep(1, 1, 3'd4);
        flagStep(2, 1, 3'd5);
        ackCool(4'b0010, 1'b1);

        // Timeout in WAIT_OPER then retry of the same grant
        ReqIn = 4'b0100;
        expCause.push_back(4'b0100);
        expCause.push_back(4'b0100);
        expAck.push_back(4'b0100);
        waitTrig();
        tick();
        flagStep(0, 0, 3'd3);
        repeat (15) tick();
        check("to_before", 32'(Phase), 32'd3);
        check("to_terr_before", 32'(TimeoutErr), 32'd0);
        tick();
        check("to_phase", 32'(Phase), 32'd1);
        check("to_retrig", 32'(rst_trigger_out), 32'd1);
        check("to_terr", 32'(TimeoutErr), 32'd1);
        check("to_retry", 32'(RetryCount), 32'd1);
        check("to_no_ack", 32'(ReqAck), 32'd0);
        tick();
        check("to_wait_rst", 32'(Phase), 32'd2);
        finishSeq(4'b0100, 1'b1);
        check("to_terr_sticky", 32'(TimeoutErr), 32'd1);

        // Enable gating at 50%; flags respond as soon as the phase is seen
        ReqIn = 4'b0001;
        expCause.push_back(4'b0001);
        expAck.push_back(4'b0001);
        gateOn = 1'b1;
        last = Phase; seen5 = 0; n = 0;
        while (n < 400 && !(seen5 && Phase == 3'd0)) begin
            tick(); n++;
            if (Phase != last) begin
                phq.push_back(Phase);
                last = Phase;
                if (Phase == 3'd5) seen5 = 1;
            end
            rstF  = (Phase == 3'd2);
            operF = (Phase == 3'd3);
            initF = (Phase == 3'd4);
            if (ReqAck != '0) ReqIn = '0;
        end
        gateOn = 1'b0;
        rstF = 1'b0; operF = 1'b0; initF = 1'b0;
        tick();
        check("gated_done", 32'(n < 400), 32'd1);
        check("gated_len", 32'(phq.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < phq.size()) check("gated_phase", 32'(phq[i]), 32'(gexp[i]));

        // Mid-sequence reset in WAIT_INIT; pointer is 1 so 1000 wins first
        ReqIn = 4'b1001;
        expCause.push_back(4'b1000);
        waitTrig();
        tick();
        flagStep(0, 1, 3'd3);
        flagStep(1, 1, 3'd4);
        sync_rst_n = 1'b0;
        tick();
        checkReset("midrst");
        sync_rst_n = 1'b1;
        expCause.push_back(4'b0001);
        expAck.push_back(4'b0001);
        waitTrig();
        ReqIn = 4'b0001;
        tick();
        finishSeq(4'b0001, 1'b1);

        repeat (5) tick();
        check("cause_queue_empty", 32'(expCause.size()), 32'd0);
        check("ack_queue_empty", 32'(expAck.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
